logic_unit_arbiter: RTL and testbench
=====================================

Name: logic_unit_arbiter

Overview:
- Shares one logical-operation datapath between two requesters, e.g. the integer issue path and a debug/microcode port.
- Each requester presents operands and a 4-bit ALU opcode under a valid/ready handshake.
- A round-robin arbiter grants one request per cycle. The block computes the logical result and holds it in a one-entry registered response buffer until the consumer accepts it.
- Sits between decode/issue and writeback.

Parameters:
- DATA_W, 32, operand and result width.
- TAG_W, 4, width of the opaque tag carried from request to response.
- CNT_W, 16, width of the per-requester grant counters (saturating).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous discard of the buffered response
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester accept; a transfer occurs when valid&ready
- req0_src1, req0_src2  in  DATA_W  requester 0 operands
- req0_op  in  4  requester 0 opcode
- req0_tag  in  TAG_W  requester 0 tag
- req1_src1, req1_src2, req1_op, req1_tag  in  as above  requester 1 payload
- resp_valid  out  1  response buffer full
- resp_ready  in  1  consumer accepts the response
- resp_data  out  DATA_W  logical result
- resp_id  out  1  requester that issued the response
- resp_tag  out  TAG_W  tag echoed from the request
- resp_err  out  1  opcode was not a logical opcode
- grant_cnt0, grant_cnt1  out  CNT_W  accepted-request counters

Behaviour:
- Reset (rst=1, asynchronous, active-high; clk is the only clock):
  - resp_valid=0, resp_data=0, resp_id=0, resp_tag=0, resp_err=0.
  - rr_ptr=0, so requester 0 is favoured.
  - grant_cnt0=grant_cnt1=0.
  - Reset mid-transfer discards the buffered response.
- Buffer state machine, two states:
  - EMPTY (resp_valid=0) and FULL (resp_valid=1).
  - can_accept = !flush && (!resp_valid || resp_ready).
- Grant (combinational):
  - If exactly one req_valid bit is set, grant that requester.
  - If both are set, grant rr_ptr.
  - req_ready[g] = can_accept; the other bit is 0.
  - req_ready never depends on req_valid of the same requester.
- Accept at a clock edge with valid&ready:
  - resp_valid<=1.
  - resp_id<=g, resp_tag<=tag_g.
  - resp_data<=f(op_g, src1_g, src2_g).
  - rr_ptr<=~g.
  - grant_cnt_g increments, saturating at all-ones.
- Latency and throughput:
  - Result is visible the cycle after acceptance.
  - One transfer per cycle when resp_ready is held high (drain and refill in the same cycle).
- Opcode function:
  - 8: src1|src2
  - 9: src1^src2
  - A: ~(src1|src2)
  - B: src1&src2
  - C: ~src1
  - Any other opcode: data=0, resp_err=1. Legal opcodes give resp_err=0.
- Drain: resp_valid && resp_ready with no new accept gives resp_valid<=0. Data, id, tag and err hold their last values.
- Backpressure: while FULL and !resp_ready, all outputs are held stable and req_ready=0.
- Requester rule: a requester must hold its payload stable while valid && !ready. The block does not check this.
- Flush:
  - Clears resp_valid at the edge.
  - Blocks acceptance that cycle.
  - rr_ptr and counters are unchanged.
  - flush with rst: rst wins.
- Counters: no wrap; they saturate and are cleared only by rst.

Decomposition:
- Shared package (logic_unit_pkg):
  - opcode constants OP_OR=4'h8, OP_XOR=4'h9, OP_NOR=4'hA, OP_AND=4'hB, OP_NOT=4'hC.
  - OP_W=4.
  - state encoding ST_EMPTY/ST_FULL.
- One sub-module, logic_op_core: purely combinational op/src1/src2 to result+err, shared with future users.
- Arbiter, buffer and counters stay in the top.

Test Plan:
- Reset: assert rst mid-FULL -> all outputs 0 immediately; after release, req0 is favoured on the first tie.
- Single request: req0 valid, op=8, src1=0x0000_00F0, src2=0x0000_000F, tag=3 -> req_ready=2'b01; next cycle resp_valid=1, data=0x0000_00FF, id=0, tag=3, err=0.
- Round-robin tie: both valid continuously, resp_ready=1 -> ids alternate 0,1,0,1 at one per cycle; grant_cnt0=grant_cnt1=2 after 4 cycles.
- Backpressure: FULL, resp_ready=0 for 3 cycles -> req_ready=0 and outputs stable. Raise resp_ready with req1 valid, op=C, src1=0 -> same-cycle drain+refill; next data=0xFFFF_FFFF, id=1.
- Illegal opcode: op=4'h3 -> data=0, err=1. A following op=B with src1=0xFF00_FF00, src2=0x0F0F_0F0F gives 0x0F00_0F00 with err=0.
- Flush and saturation:
  - flush while FULL -> resp_valid=0 next cycle, no accept that cycle, rr_ptr unchanged.
  - With CNT_W=2, 5 grants -> grant_cnt0=3.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared opcode constants and response-buffer state encoding for the logical-operation unit.
package logic_unit_pkg;

   localparam int OP_W = 4;

   localparam logic [OP_W-1:0] OP_OR  = 4'h8;
   localparam logic [OP_W-1:0] OP_XOR = 4'h9;
   localparam logic [OP_W-1:0] OP_NOR = 4'hA;
   localparam logic [OP_W-1:0] OP_AND = 4'hB;
   localparam logic [OP_W-1:0] OP_NOT = 4'hC;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } buf_state_e;

endpackage

// File: rtl/logic_op_core.sv
// Combinational logical-op evaluator: opcode + two operands -> result and illegal-opcode flag.
// Zero latency, no flow control; unknown opcodes produce a zero result with err set.
module logic_op_core
   import logic_unit_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [OP_W-1:0]   op_i,
   input  logic [DATA_W-1:0] src1_i,
   input  logic [DATA_W-1:0] src2_i,
   output logic [DATA_W-1:0] result_o,
   output logic              err_o
);

   always_comb begin
      result_o = '0;
      err_o    = 1'b0;
      case (op_i)
         OP_OR:   result_o = src1_i | src2_i;
         OP_XOR:  result_o = src1_i ^ src2_i;
         OP_NOR:  result_o = ~(src1_i | src2_i);
         OP_AND:  result_o = src1_i & src2_i;
         OP_NOT:  result_o = ~src1_i;
         default: err_o    = 1'b1;
      endcase
   end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin front end to one logical-op core with a one-entry response buffer.
// Result one cycle after accept; full throughput when resp_ready is high, req_ready drops while full and stalled.
module logic_unit_arbiter
   import logic_unit_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [DATA_W-1:0] req0_src1,
   input  logic [DATA_W-1:0] req0_src2,
   input  logic [OP_W-1:0]   req0_op,
   input  logic [TAG_W-1:0]  req0_tag,
   input  logic [DATA_W-1:0] req1_src1,
   input  logic [DATA_W-1:0] req1_src2,
   input  logic [OP_W-1:0]   req1_op,
   input  logic [TAG_W-1:0]  req1_tag,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_id,
   output logic [TAG_W-1:0]  resp_tag,
   output logic              resp_err,
   output logic [CNT_W-1:0]  grant_cnt0,
   output logic [CNT_W-1:0]  grant_cnt1
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   buf_state_e        state_q, state_d;
   logic              rr_ptr_q, rr_ptr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              id_q, id_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;

   logic              can_accept, xfer, gsel, core_err;
   logic [DATA_W-1:0] sel_src1, sel_src2, core_res;
   logic [OP_W-1:0]   sel_op;
   logic [TAG_W-1:0]  sel_tag;

   assign resp_valid = (state_q == ST_FULL);
   assign can_accept = !flush && (!resp_valid || resp_ready);

   // Each ready looks only at the other requester's valid, so no requester sees its own valid fed back.
   assign req_ready[0] = can_accept && (!rr_ptr_q || !req_valid[1]);
   assign req_ready[1] = can_accept && ( rr_ptr_q || !req_valid[0]);

   assign gsel = req_valid[1] && req_ready[1];
   assign xfer = |(req_valid & req_ready);

   assign sel_src1 = gsel ? req1_src1 : req0_src1;
   assign sel_src2 = gsel ? req1_src2 : req0_src2;
   assign sel_op   = gsel ? req1_op   : req0_op;
   assign sel_tag  = gsel ? req1_tag  : req0_tag;

   logic_op_core #(.DATA_W(DATA_W)) u_core (
      .op_i     (sel_op),
      .src1_i   (sel_src1),
      .src2_i   (sel_src2),
      .result_o (core_res),
      .err_o    (core_err)
   );

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      data_d   = data_q;
      id_d     = id_q;
      tag_d    = tag_q;
      err_d    = err_q;
      cnt0_d   = cnt0_q;
      cnt1_d   = cnt1_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else if (xfer) begin
         state_d  = ST_FULL;
         data_d   = core_res;
         id_d     = gsel;
         tag_d    = sel_tag;
         err_d    = core_err;
         rr_ptr_d = ~gsel;
         if (!gsel && cnt0_q != '1) cnt0_d = cnt0_q + CNT_ONE;
         if ( gsel && cnt1_q != '1) cnt1_d = cnt1_q + CNT_ONE;
      end else if (resp_valid && resp_ready) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_EMPTY;
         rr_ptr_q <= 1'b0;
         data_q   <= '0;
         id_q     <= 1'b0;
         tag_q    <= '0;
         err_q    <= 1'b0;
         cnt0_q   <= '0;
         cnt1_q   <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         data_q   <= data_d;
         id_q     <= id_d;
         tag_q    <= tag_d;
         err_q    <= err_d;
         cnt0_q   <= cnt0_d;
         cnt1_q   <= cnt1_d;
      end
   end

   assign resp_data  = data_q;
   assign resp_id    = id_q;
   assign resp_tag   = tag_q;
   assign resp_err   = err_q;
   assign grant_cnt0 = cnt0_q;
   assign grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench with a response scoreboard; a second instance with 2-bit counters exercises saturation.
module tb_logic_unit_arbiter;

   typedef struct packed {
      logic [31:0] data;
      logic        id;
      logic [3:0]  tag;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, flush, resp_ready;
   logic [1:0]  req_valid;
   logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
   logic [3:0]  req0_op, req1_op, req0_tag, req1_tag;

   logic [1:0]  req_ready, req_ready_s;
   logic        resp_valid, resp_id, resp_err, resp_valid_s, resp_id_s, resp_err_s;
   logic [31:0] resp_data, resp_data_s;
   logic [3:0]  resp_tag, resp_tag_s;
   logic [15:0] grant_cnt0, grant_cnt1;
   logic [1:0]  grant_cnt0_s, grant_cnt1_s;

   int    nchecks = 0;
   int    nerr    = 0;
   exp_t  sbq[$];
   exp_t  m_last;
   logic  mvalid;
   logic  m_rr;
   int    m_cnt[2];

   always #5 clk = ~clk;

   logic_unit_arbiter dut (
      .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
      .req0_src1(req0_src1), .req0_src2(req0_src2), .req0_op(req0_op), .req0_tag(req0_tag),
      .req1_src1(req1_src1), .req1_src2(req1_src2), .req1_op(req1_op), .req1_tag(req1_tag),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_id(resp_id), .resp_tag(resp_tag), .resp_err(resp_err),
      .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
   );

   logic_unit_arbiter #(.CNT_W(2)) dut_s (
      .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready_s),
      .req0_src1(req0_src1), .req0_src2(req0_src2), .req0_op(req0_op), .req0_tag(req0_tag),
      .req1_src1(req1_src1), .req1_src2(req1_src2), .req1_op(req1_op), .req1_tag(req1_tag),
      .resp_valid(resp_valid_s), .resp_ready(resp_ready), .resp_data(resp_data_s),
      .resp_id(resp_id_s), .resp_tag(resp_tag_s), .resp_err(resp_err_s),
      .grant_cnt0(grant_cnt0_s), .grant_cnt1(grant_cnt1_s)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic id, input logic [3:0] op,
                                  input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
      exp_t e;
      e.id = id; e.tag = tag; e.err = 1'b0; e.data = 32'h0;
      case (op)
         4'h8:    e.data = a | b;
         4'h9:    e.data = a ^ b;
         4'hA:    e.data = ~(a | b);
         4'hB:    e.data = a & b;
         4'hC:    e.data = ~a;
         default: e.err  = 1'b1;
      endcase
      return e;
   endfunction

   function automatic logic [31:0] sat(input int v, input int maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   task automatic model_reset();
      sbq.delete();
      m_last = '0; mvalid = 1'b0; m_rr = 1'b0;
      m_cnt[0] = 0; m_cnt[1] = 0;
   endtask

   // One clock: compare outputs mid-cycle against the model, then advance the model across the edge.
   task automatic cycle();
      exp_t       e;
      logic       ca, g;
      logic [1:0] gm, exp_rdy;
      @(negedge clk);
      chk("resp_valid", resp_valid, mvalid);
      e = (mvalid && sbq.size() > 0) ? sbq[0] : m_last;
      chk("resp_data", resp_data, e.data);
      chk("resp_id", resp_id, e.id);
      chk("resp_tag", resp_tag, e.tag);
      chk("resp_err", resp_err, e.err);
      chk("grant_cnt0", grant_cnt0, sat(m_cnt[0], 65535));
      chk("grant_cnt1", grant_cnt1, sat(m_cnt[1], 65535));
      chk("grant_cnt0_sat", grant_cnt0_s, sat(m_cnt[0], 3));
      chk("grant_cnt1_sat", grant_cnt1_s, sat(m_cnt[1], 3));
      ca = !flush && (!mvalid || resp_ready);
      gm = (req_valid == 2'b11) ? (m_rr ? 2'b10 : 2'b01) : req_valid;
      exp_rdy = ca ? gm : 2'b00;
      chk("grant", req_ready & req_valid, exp_rdy);
      if (mvalid && (flush || resp_ready) && sbq.size() > 0) m_last = sbq.pop_front();
      if (flush) begin
         mvalid = 1'b0;
      end else if (exp_rdy != 2'b00) begin
         g = exp_rdy[1];
         if (g) sbq.push_back(model(1'b1, req1_op, req1_src1, req1_src2, req1_tag));
         else   sbq.push_back(model(1'b0, req0_op, req0_src1, req0_src2, req0_tag));
         mvalid = 1'b1;
         m_rr = ~g;
         m_cnt[g]++;
      end else if (mvalid && resp_ready) begin
         mvalid = 1'b0;
      end
      @(posedge clk); #1;
   endtask

   task automatic set0(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
      req0_op = op; req0_src1 = a; req0_src2 = b; req0_tag = tag;
   endtask

   task automatic set1(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
      req1_op = op; req1_src1 = a; req1_src2 = b; req1_tag = tag;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; resp_ready = 1'b0; req_valid = 2'b00;
      set0(4'h0, 32'h0, 32'h0, 4'h0);
      set1(4'h0, 32'h0, 32'h0, 4'h0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", resp_valid, 1'b0);
      chk("rst_data", resp_data, 32'h0);
      chk("rst_cnt0", grant_cnt0, 16'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Single request from requester 0
      set0(4'h8, 32'h0000_00F0, 32'h0000_000F, 4'h3);
      req_valid = 2'b01;
      #1 chk("single_ready", req_ready, 2'b01);
      cycle();
      req_valid = 2'b00;
      cycle();
      chk("single_data", resp_data, 32'h0000_00FF);
      chk("single_tag", resp_tag, 4'h3);

      // Reset while FULL clears outputs immediately
      rst = 1'b1;
      #1;
      chk("midrst_valid", resp_valid, 1'b0);
      chk("midrst_data", resp_data, 32'h0);
      chk("midrst_tag", resp_tag, 4'h0);
      chk("midrst_cnt0", grant_cnt0, 16'h0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;

      // Round-robin tie at full throughput
      set0(4'h9, 32'hA5A5_0000, 32'h0F0F_F0F0, 4'h1);
      set1(4'hA, 32'h1234_5678, 32'h0000_FFFF, 4'h2);
      req_valid = 2'b11; resp_ready = 1'b1;
      #1 chk("tie_first_ready", req_ready, 2'b01);
      repeat (4) cycle();
      chk("tie_cnt0", grant_cnt0, 16'd2);
      chk("tie_cnt1", grant_cnt1, 16'd2);
      req_valid = 2'b00;
      cycle();

      // Backpressure then same-cycle drain and refill
      set0(4'hB, 32'hFFFF_0000, 32'hF0F0_F0F0, 4'h5);
      req_valid = 2'b01; resp_ready = 1'b0;
      cycle();
      set1(4'hC, 32'h0, 32'h0, 4'h7);
      req_valid = 2'b10;
      repeat (3) cycle();
      chk("bp_ready", req_ready, 2'b00);
      resp_ready = 1'b1;
      cycle();
      req_valid = 2'b00; resp_ready = 1'b0;
      cycle();
      chk("refill_data", resp_data, 32'hFFFF_FFFF);
      chk("refill_id", resp_id, 1'b1);

      // Illegal opcode followed by a legal AND
      resp_ready = 1'b1;
      set0(4'h3, 32'hDEAD_BEEF, 32'h1111_1111, 4'h9);
      req_valid = 2'b01;
      cycle();
      set0(4'hB, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'hA);
      cycle();
      req_valid = 2'b00;
      cycle();

      // Flush while FULL blocks that cycle's accept and keeps the pointer
      set0(4'h8, 32'h1, 32'h2, 4'h4);
      req_valid = 2'b01; resp_ready = 1'b0;
      cycle();
      set1(4'h9, 32'hFFFF_FFFF, 32'h0000_0001, 4'h6);
      req_valid = 2'b11; flush = 1'b1;
      cycle();
      flush = 1'b0;
      chk("flush_valid", resp_valid, 1'b0);
      resp_ready = 1'b1;
      repeat (2) cycle();

      // Counter saturation on the 2-bit instance
      req_valid = 2'b01;
      set0(4'hC, 32'h5555_AAAA, 32'h0, 4'hF);
      repeat (6) cycle();
      chk("sat_cnt0", grant_cnt0_s, 2'd3);
      req_valid = 2'b00;
      repeat (2) cycle();

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end

endmodule
